// File: rtl/iic_pkg.sv
// Shared constants for the I2C write master: FSM state codes, quarter indices
// and the byte selector for the outgoing byte list.
package iic_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BIT   = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BUF   = 3'd5;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BUF_QUARTERS = 4;

    // Byte slot 1 (register address high) is only ever selected for 16-bit registers.
    function automatic logic [7:0] pick_byte(input logic [1:0]  idx,
                                             input logic [7:0]  addr,
                                             input logic [15:0] reg_addr,
                                             input logic [7:0]  data);
        case (idx)
            2'd0:    return addr;
            2'd1:    return reg_addr[15:8];
            2'd2:    return reg_addr[7:0];
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/iic_qtick.sv
// Quarter-SCL-period divider: ticks every QDIV clocks and counts quarters 0..3.
// A synchronous restart realigns both counters to the request accept.
module iic_qtick #(
    parameter int QDIV = 25
) (
    input  logic       clk_10MHz,
    input  logic       rst_n,
    input  logic       restart,
    output logic       qtick,
    output logic [1:0] qidx
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] cnt;

    assign qtick = (cnt == CW'(QDIV - 1));

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            qidx <= 2'd0;
        end else if (restart) begin
            cnt  <= '0;
            qidx <= 2'd0;
        end else if (qtick) begin
            cnt  <= '0;
            qidx <= qidx + 2'd1;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/iic_write_master.sv
// Byte-oriented I2C write master fed by the OV5647 register-init sequencer.
// Sends Addr, [Reg_Addr hi], Reg_Addr lo, Reg_Data with open-drain enables.
module iic_write_master
    import iic_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int SCL_FREQ_HZ = 100_000
) (
    input  logic        clk_10MHz,
    input  logic        rst_n,
    input  logic        Ctrl_IIC,
    input  logic        IIC_Write,
    input  logic [7:0]  Addr,
    input  logic [15:0] Reg_Addr,
    input  logic        Reg2Addr,
    input  logic [7:0]  Reg_Data,
    output logic        IIC_Busy,
    output logic        Ack_Err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);

    logic [2:0]  state;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  addr_q;
    logic [15:0] reg_addr_q;
    logic        reg2_q;
    logic [7:0]  data_q;
    logic        qtick;
    logic [1:0]  q;
    logic        accept;
    logic        q_end;
    logic [7:0]  cur_byte;
    logic        scl_nxt;
    logic        sda_nxt;

    assign accept   = (state == IDLE) && Ctrl_IIC && IIC_Write;
    assign q_end    = qtick && (q == Q3);
    assign cur_byte = pick_byte(byte_idx, addr_q, reg_addr_q, data_q);

    iic_qtick #(.QDIV(QDIV)) u_qtick (
        .clk_10MHz (clk_10MHz),
        .rst_n     (rst_n),
        .restart   (accept),
        .qtick     (qtick),
        .qidx      (q)
    );

    // Operands are captured once per request; upstream may change them while busy.
    always_ff @(posedge clk_10MHz) begin
        if (accept) begin
            addr_q     <= Addr;
            reg_addr_q <= Reg_Addr;
            reg2_q     <= Reg2Addr;
            data_q     <= Reg_Data;
        end
    end

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            IIC_Busy <= 1'b0;
            Ack_Err  <= 1'b0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= START;
                    IIC_Busy <= 1'b1;
                    Ack_Err  <= 1'b0;
                end
                START: if (q_end) begin
                    state    <= BIT;
                    bit_idx  <= 3'd7;
                    byte_idx <= 2'd0;
                end
                BIT: if (q_end) begin
                    if (bit_idx == 3'd0) state <= ACK;
                    else                 bit_idx <= bit_idx - 3'd1;
                end
                ACK: begin
                    // Slave drives SDA while SCL is high; sample late in that window.
                    if (qtick && (q == Q2) && sda_i) Ack_Err <= 1'b1;
                    if (q_end) begin
                        if (Ack_Err || (byte_idx == 2'd3)) begin
                            state <= STOP;
                        end else begin
                            state    <= BIT;
                            bit_idx  <= 3'd7;
                            byte_idx <= ((byte_idx == 2'd0) && !reg2_q) ? 2'd2 : byte_idx + 2'd1;
                        end
                    end
                end
                STOP: if (q_end) state <= BUF;
                BUF: if (qtick && (q == 2'(BUF_QUARTERS - 1))) begin
                    state    <= IDLE;
                    IIC_Busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    IIC_Busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
        case (state)
            START: sda_nxt = (q == Q2) || (q == Q3);
            BIT: begin
                scl_nxt = (q == Q0) || (q == Q1);
                sda_nxt = ~cur_byte[bit_idx];
            end
            ACK:  scl_nxt = (q == Q0) || (q == Q1);
            STOP: begin
                scl_nxt = (q == Q0);
                sda_nxt = (q == Q0) || (q == Q1);
            end
            default: ;
        endcase
    end

    // Registered pad enables keep SCL/SDA glitch-free across state changes.
    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            scl_oe <= scl_nxt;
            sda_oe <= sda_nxt;
        end
    end

endmodule

// File: tb/tb_iic_write_master.sv
// Bench for iic_write_master: wired-AND bus with a byte-decoding slave, a
// request-level model of busy time / bytes / Ack_Err, and directed scenarios.
module tb_iic_write_master;

    localparam int QA = 10_000_000 / (4 * 100_000);
    localparam int QB = 10_000_000 / (4 * 1_250_000);

    logic        clk_10MHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        Ctrl_IIC  = 1'b0;
    logic        IIC_Write = 1'b0;
    logic [7:0]  Addr      = 8'h00;
    logic [15:0] Reg_Addr  = 16'h0000;
    logic        Reg2Addr  = 1'b0;
    logic [7:0]  Reg_Data  = 8'h00;
    logic        sel       = 1'b0;
    logic        slave_pull = 1'b0;

    logic busy_a, busy_b, err_a, err_b;
    logic scl_oe_a, scl_oe_b, sda_oe_a, sda_oe_b;

    wire ctrl_a   = Ctrl_IIC & ~sel;
    wire ctrl_b   = Ctrl_IIC & sel;
    wire scl_line = ~(scl_oe_a | scl_oe_b);
    wire sda_line = ~(sda_oe_a | sda_oe_b | slave_pull);
    wire busy_s   = sel ? busy_b : busy_a;
    wire err_s    = sel ? err_b : err_a;

    int          n_cmp = 0, n_fail = 0;
    int          m_rem = 0, m_n = 0, m_sent = 0;
    logic        m_err = 1'b0;
    logic [7:0]  m_b [4];
    int          nack_at = 255;
    logic [7:0]  exp_q [$];
    logic [7:0]  got_log [$];
    int          n_start = 0, n_stop = 0, cur_len = 0, last_len = 0;
    int          bitcnt = 0, fbyte = 0;
    logic [7:0]  shreg = 8'h00;
    logic        cs, cd, p_scl = 1'b1, p_sda = 1'b1;
    logic        err_at_start = 1'b0;

    iic_write_master u_dut_a (
        .clk_10MHz (clk_10MHz), .rst_n (rst_n), .Ctrl_IIC (ctrl_a), .IIC_Write (IIC_Write),
        .Addr (Addr), .Reg_Addr (Reg_Addr), .Reg2Addr (Reg2Addr), .Reg_Data (Reg_Data),
        .IIC_Busy (busy_a), .Ack_Err (err_a), .scl_oe (scl_oe_a), .sda_oe (sda_oe_a),
        .sda_i (sda_line)
    );

    iic_write_master #(.CLK_FREQ_HZ(10_000_000), .SCL_FREQ_HZ(1_250_000)) u_dut_b (
        .clk_10MHz (clk_10MHz), .rst_n (rst_n), .Ctrl_IIC (ctrl_b), .IIC_Write (IIC_Write),
        .Addr (Addr), .Reg_Addr (Reg_Addr), .Reg2Addr (Reg2Addr), .Reg_Data (Reg_Data),
        .IIC_Busy (busy_b), .Ack_Err (err_b), .scl_oe (scl_oe_b), .sda_oe (sda_oe_b),
        .sda_i (sda_line)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Request-level model: one request = byte list + busy time of (36*sent+12) quarters.
    initial forever begin
        @(posedge clk_10MHz);
        if (!rst_n) begin
            m_rem = 0;
            m_err = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (Ctrl_IIC && IIC_Write) begin
            m_n    = Reg2Addr ? 4 : 3;
            m_b[0] = Addr;
            m_b[1] = Reg2Addr ? Reg_Addr[15:8] : Reg_Addr[7:0];
            m_b[2] = Reg2Addr ? Reg_Addr[7:0]  : Reg_Data;
            m_b[3] = Reg_Data;
            m_sent = (nack_at < m_n) ? nack_at + 1 : m_n;
            m_err  = (nack_at < m_n);
            m_rem  = (36 * m_sent + 12) * (sel ? QB : QA);
            for (int k = 0; k < m_sent; k++) exp_q.push_back(m_b[k]);
        end
    end

    // Compare process plus slave: decodes START/STOP/bytes on the wired bus and ACKs.
    initial forever begin
        @(negedge clk_10MHz);
        cs = scl_line;
        cd = sda_line;
        if (!rst_n) begin
            slave_pull = 1'b0;
            bitcnt = 0;
            fbyte = 0;
            cur_len = 0;
            exp_q.delete();
            p_scl = 1'b1;
            p_sda = 1'b1;
        end else begin
            chk("busy", int'(busy_s), int'(m_rem > 0));
            if (m_rem == 0) begin
                chk("scl_idle", int'(scl_oe_a | scl_oe_b), 0);
                chk("sda_idle", int'(sda_oe_a | sda_oe_b), 0);
                chk("ack_err", int'(err_s), int'(m_err));
            end
            if (busy_s) cur_len++;
            else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len = 0;
            end
            if (p_scl && cs && p_sda && !cd) begin
                n_start++;
                bitcnt = 0;
                fbyte = 0;
            end
            if (p_scl && cs && !p_sda && cd) n_stop++;
            if (!p_scl && cs) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], cd};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        fbyte++;
                        got_log.push_back(shreg);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL byte_unexpected: got %0h, expected none", shreg);
                        end else begin
                            chk("byte", int'(shreg), int'(exp_q.pop_front()));
                        end
                    end
                end else begin
                    bitcnt = 0;
                end
            end
            if (p_scl && !cs) slave_pull = (bitcnt == 8) && ((fbyte - 1) != nack_at);
            p_scl = cs;
            p_sda = cd;
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (busy_s != lvl && n < budget) begin
            @(negedge clk_10MHz);
            n++;
        end
        if (busy_s != lvl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: busy=%0b after %0d cycles, expected %0b", nm, busy_s, n, lvl);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] ra, input logic r2,
                            input logic [7:0] d, input logic drop_ctrl);
        @(negedge clk_10MHz);
        Addr = a; Reg_Addr = ra; Reg2Addr = r2; Reg_Data = d;
        Ctrl_IIC = 1'b1;
        IIC_Write = 1'b1;
        @(negedge clk_10MHz);
        wait_busy(1'b1, 4, "accept");
        err_at_start = err_s;
        IIC_Write = 1'b0;
        if (drop_ctrl) Ctrl_IIC = 1'b0;
        wait_busy(1'b0, 5000, "done");
        Ctrl_IIC = 1'b1;
        @(negedge clk_10MHz);
    endtask

    task automatic chk_log(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, got_log.size(), n);
        for (int k = 0; k < n && k < got_log.size(); k++) chk(nm, int'(got_log[k]), int'(e[k]));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, t0, n;
        repeat (3) @(negedge clk_10MHz);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_scl", int'(scl_oe_a), 0);
        chk("rst_sda", int'(sda_oe_a), 0);
        @(posedge clk_10MHz);
        #10 rst_n = 1'b1;
        repeat (2) @(negedge clk_10MHz);

        got_log.delete();
        do_write(8'h6C, 16'h0100, 1'b1, 8'h01, 1'b0);
        chk("len16", last_len, 3900);
        chk("err16", int'(err_s), 0);
        chk_log("bytes16", 8'h6C, 8'h01, 8'h00, 8'h01, 4);

        got_log.delete();
        do_write(8'h6C, 16'h0012, 1'b0, 8'h80, 1'b0);
        chk("len8", last_len, 3000);
        chk_log("bytes8", 8'h6C, 8'h12, 8'h80, 8'h00, 3);

        nack_at = 0;
        got_log.delete();
        t0 = n_stop;
        do_write(8'h6C, 16'h0100, 1'b1, 8'h01, 1'b0);
        chk("len_nack", last_len, 1200);
        chk("err_nack", int'(err_s), 1);
        chk("stop_nack", n_stop - t0, 1);
        chk_log("bytes_nack", 8'h6C, 8'h00, 8'h00, 8'h00, 1);
        nack_at = 255;

        do_write(8'h5A, 16'h3008, 1'b1, 8'h42, 1'b0);
        chk("err_clear_accept", int'(err_at_start), 0);
        chk("err_after_ok", int'(err_s), 0);
        chk("len_clear", last_len, 3900);

        got_log.delete();
        @(negedge clk_10MHz);
        Ctrl_IIC = 1'b0;
        IIC_Write = 1'b1;
        repeat (200) @(negedge clk_10MHz);
        chk("gated_busy", int'(busy_a), 0);
        chk("gated_bytes", got_log.size(), 0);
        IIC_Write = 1'b0;

        got_log.delete();
        do_write(8'h6C, 16'h0034, 1'b0, 8'hA5, 1'b1);
        chk("len_ctrl_drop", last_len, 3000);
        chk_log("bytes_ctrl_drop", 8'h6C, 8'h34, 8'hA5, 8'h00, 3);

        @(negedge clk_10MHz);
        Addr = 8'h6C; Reg_Addr = 16'h0100; Reg2Addr = 1'b1; Reg_Data = 8'h01;
        Ctrl_IIC = 1'b1;
        IIC_Write = 1'b1;
        n = 0;
        while (!(scl_oe_a | sda_oe_a) && n < 400) begin
            @(negedge clk_10MHz);
            n++;
        end
        chk("rst_mid_active", int'(scl_oe_a | sda_oe_a), 1);
        IIC_Write = 1'b0;
        #20 rst_n = 1'b0;
        #10;
        chk("rst_async_scl", int'(scl_oe_a), 0);
        chk("rst_async_sda", int'(sda_oe_a), 0);
        chk("rst_async_busy", int'(busy_a), 0);
        repeat (3) @(negedge clk_10MHz);
        @(posedge clk_10MHz);
        #10 rst_n = 1'b1;
        repeat (100) @(negedge clk_10MHz);
        chk("rst_stays_idle", int'(busy_a), 0);

        @(negedge clk_10MHz);
        sel = 1'b1;
        s0 = n_start;
        t0 = n_stop;
        Addr = 8'h6C; Reg_Addr = 16'h3000; Reg2Addr = 1'b0; Reg_Data = 8'd3;
        Ctrl_IIC = 1'b1;
        IIC_Write = 1'b1;
        @(negedge clk_10MHz);
        wait_busy(1'b1, 4, "b2b_first");
        for (int i = 0; i < 88; i++) begin
            wait_busy(1'b0, 400, "b2b_done");
            if (i < 87) begin
                Reg_Addr = 16'h3000 + 16'((i + 1) * 37);
                Reg2Addr = ((i + 1) % 2 == 1);
                Reg_Data = 8'((i + 1) * 5 + 3);
                @(negedge clk_10MHz);
                chk("b2b_gap", int'(busy_s), 1);
            end else begin
                IIC_Write = 1'b0;
            end
        end
        repeat (3) @(negedge clk_10MHz);
        chk("b2b_starts", n_start - s0, 88);
        chk("b2b_stops", n_stop - t0, 88);
        chk("b2b_drain", exp_q.size(), 0);
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_write_master.md
Name: iic_write_master

Overview:
- Byte-oriented I2C write master that sits directly downstream of the OV5647 register-init sequencer.
- Consumes one request per register: 7-bit device address (pre-shifted, R/W=0), 8- or 16-bit register address, one data byte.
- Drives open-drain SCL/SDA through top-level IOBUFs.
- Reports IIC_Busy; the sequencer uses the IIC_Busy falling edge to load the next register.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock frequency.
- SCL_FREQ_HZ, 100_000, target SCL rate.
- QDIV, CLK_FREQ_HZ/(4*SCL_FREQ_HZ) = 25, clocks per quarter SCL period (derived localparam, ≥2).

Ports:
- clk_10MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- Ctrl_IIC  in  1  1 = block owns bus and may accept requests; 0 = requests ignored.
- IIC_Write  in  1  level request; accepted in IDLE when high.
- Addr  in  8  device address byte, bit0 must be 0 (write); sent as-is.
- Reg_Addr  in  16  register address.
- Reg2Addr  in  1  1 = send Reg_Addr[15:8] then [7:0]; 0 = send [7:0] only.
- Reg_Data  in  8  data byte.
- IIC_Busy  out  1  high from accept until bus-free time after STOP.
- Ack_Err  out  1  sticky NACK flag for the last transfer.
- scl_oe  out  1  1 = pull SCL low.
- sda_oe  out  1  1 = pull SDA low.
- sda_i  in  1  SDA pad input, used for ACK sampling.

Behaviour:
- Reset (async, rst_n=0): IIC_Busy=0, Ack_Err=0, scl_oe=0, sda_oe=0, state IDLE, quarter counter=0.
- Reset mid-transfer releases both lines immediately; no STOP is generated.
- Quarter tick: counter runs 0..QDIV-1 and ticks at QDIV-1. It restarts at 0 on accept, so all phases are QDIV-aligned to accept.
- Accept: in IDLE with Ctrl_IIC=1 and IIC_Write=1, register Addr, Reg_Addr, Reg2Addr and Reg_Data. Clear Ack_Err. IIC_Busy goes to 1 on the next clock edge.
- Inputs are ignored while busy. Ctrl_IIC falling mid-transfer does not abort the transfer.
- Byte list: Addr, [Reg_Addr hi if Reg2Addr], Reg_Addr lo, Reg_Data. N = 4 with Reg2Addr=1, N = 3 otherwise.
- START (4 quarters): q0-q1 SCL and SDA released; q2 SDA low; q3 SCL high held.
- BIT (4 quarters per bit, MSB first, 8 per byte):
  - q0: SCL low, SDA set to bit (sda_oe = ~bit).
  - q1: SCL low.
  - q2-q3: SCL released.
- ACK (4 quarters):
  - q0: SCL low, SDA released.
  - q2: SCL released.
  - Sample sda_i on the tick ending q2. 1 = NACK.
- On NACK: set Ack_Err=1 and skip remaining bytes; go to STOP. On ACK: go to the next byte, or to STOP after the last byte.
- STOP (4 quarters): q0 SCL low, SDA low; q1 SCL released; q2 SDA released; q3 hold.
- BUF (4 quarters): lines released. At the end, IIC_Busy goes to 0 and the state returns to IDLE.
- Total busy duration, full ACK: (36N+12)*QDIV cycles. N=3 gives 3000 cycles; N=4 gives 3900 cycles at defaults.
- Back-to-back: if IIC_Write is still high in the IDLE cycle after busy falls, accept immediately (one idle clock minimum). Upstream must update its operands on the busy falling edge.
- No clock stretching, no arbitration, no read support.
- State machine: IDLE → START → BIT → ACK → (BIT | STOP) → BUF → IDLE.
- Bit index is 3 bits (7→0). Byte index is 2 bits; Reg2Addr=0 skips index 1.

Decomposition:
- Package iic_pkg: state enum (IDLE, START, BIT, ACK, STOP, BUF), quarter-index constants Q0..Q3, BUF_QUARTERS=4.
- Sub-module iic_qtick: quarter-period divider with a sync restart input; outputs qtick and a 2-bit quarter index.

Test Plan:
- Reset: hold rst_n=0 during an active transfer → scl_oe=sda_oe=0 and IIC_Busy=0 immediately, with no clock edge required.
- 16-bit write: Addr=8'h6C, Reg_Addr=16'h0100, Reg_Data=8'h01, Reg2Addr=1, slave model ACKs all bytes → bytes 6C,01,00,01 decoded, Ack_Err=0, IIC_Busy high for 3900 cycles.
- 8-bit write: Reg2Addr=0, Reg_Addr=16'h0012, Reg_Data=8'h80 → bytes 6C,12,80 decoded, busy for 3000 cycles.
- NACK: slave NACKs the address byte → STOP follows ACK slot 0, Ack_Err=1, busy for (36+12)*25=1200 cycles. Ack_Err clears on the next accept.
- Back-to-back: IIC_Write held high and upstream model updates Reg_Addr on busy negedge across 88 writes → 88 STARTs, data matches the model list, one idle clock between transfers.
- Gating: Ctrl_IIC=0 with IIC_Write=1 → no accept, lines stay released. Ctrl_IIC dropped mid-transfer → transfer completes normally.
